// File: rtl/score_display_pkg.sv
// Shared segment patterns and FSM state type for the score display.
// Patterns are active-low: bit 6 = g ... bit 0 = a.
package score_display_pkg;

    localparam int unsigned SEG_W = 7;

    localparam logic [SEG_W-1:0] SEG_DIGIT [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_DASH  = 7'b0111111;

    localparam logic [SEG_W-1:0] SEG_S = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_C = 7'b1000110;
    localparam logic [SEG_W-1:0] SEG_O = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_R = 7'b0101111;
    localparam logic [SEG_W-1:0] SEG_E = 7'b0000110;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/seg7_encode.sv
// Combinational BCD digit to active-low seven-segment pattern; non-decimal codes blank.
module seg7_encode
    import score_display_pkg::*;
(
    input  logic [3:0]       bcd,
    output logic [SEG_W-1:0] seg_c
);

    always_comb begin
        seg_c = SEG_BLANK;
        case (bcd)
            4'd0:    seg_c = SEG_DIGIT[0];
            4'd1:    seg_c = SEG_DIGIT[1];
            4'd2:    seg_c = SEG_DIGIT[2];
            4'd3:    seg_c = SEG_DIGIT[3];
            4'd4:    seg_c = SEG_DIGIT[4];
            4'd5:    seg_c = SEG_DIGIT[5];
            4'd6:    seg_c = SEG_DIGIT[6];
            4'd7:    seg_c = SEG_DIGIT[7];
            4'd8:    seg_c = SEG_DIGIT[8];
            4'd9:    seg_c = SEG_DIGIT[9];
            default: seg_c = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/score_bcd_display.sv
// Sequential double-dabble score to seven-segment driver with LOAD/BUSY/DONE handshake.
// Optional leading-zero blanking enabled by defining SCORE_ZERO_BLANK_EN.
module score_bcd_display
    import score_display_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                  CLOCK_50,
    input  logic                  RESET_N,
    input  logic [WIDTH-1:0]      SCORE,
    input  logic                  LOAD,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  OVF,
    output logic [7*DIGITS-1:0]   HEX_DIGITS,
    output logic [34:0]           HEX_LABEL
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned HEX_W = SEG_W * DIGITS;

    // Display shown after reset: value 0 under the active blanking rule.
    function automatic logic [HEX_W-1:0] reset_hex();
        logic [HEX_W-1:0] h;
        h = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
`ifdef SCORE_ZERO_BLANK_EN
            h[SEG_W*i +: SEG_W] = (i == 0) ? SEG_DIGIT[0] : SEG_BLANK;
`else
            h[SEG_W*i +: SEG_W] = SEG_DIGIT[0];
`endif
        end
        return h;
    endfunction

    localparam logic [HEX_W-1:0] HEX_RST = reset_hex();

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   bin_q, bin_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_acc_q, ovf_acc_d;
    logic               pend_q, pend_d;
    logic [WIDTH-1:0]   pend_val_q, pend_val_d;
    logic [HEX_W-1:0]   hex_q, hex_d;
    logic               ovf_q, ovf_d;
    logic               done_q, done_d;

    logic [BCD_W-1:0]   bcd_adj_c;
    logic [BCD_W-1:0]   bcd_shift_c;
    logic               carry_c;
    logic               commit_ovf_c;
    logic               last_c;
    logic [SEG_W-1:0]   seg_c [DIGITS];
    logic [DIGITS-1:0]  show_c;
    logic [HEX_W-1:0]   hex_c;
`ifdef SCORE_ZERO_BLANK_EN
    logic               seen_c;
`endif

    // Add-3 correction then one-bit shift of {bcd, bin}.
    always_comb begin
        bcd_adj_c = bcd_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj_c[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    assign bcd_shift_c  = {bcd_adj_c[BCD_W-2:0], bin_q[WIDTH-1]};
    assign carry_c      = bcd_adj_c[BCD_W-1];
    assign commit_ovf_c = ovf_acc_q | carry_c;
    assign last_c       = (cnt_q == CNT_W'(WIDTH - 1));

    for (genvar g = 0; g < int'(DIGITS); g++) begin : g_enc
        seg7_encode u_enc (
            .bcd   (bcd_shift_c[4*g +: 4]),
            .seg_c (seg_c[g])
        );
    end

    // Digit visibility mask; the ones digit is always shown.
    always_comb begin
        show_c = '1;
`ifdef SCORE_ZERO_BLANK_EN
        seen_c = 1'b0;
        for (int i = int'(DIGITS) - 1; i > 0; i--) begin
            seen_c    = seen_c | (bcd_shift_c[4*i +: 4] != 4'd0);
            show_c[i] = seen_c;
        end
`endif
    end

    always_comb begin
        hex_c = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (commit_ovf_c) begin
                hex_c[SEG_W*i +: SEG_W] = SEG_DASH;
            end else if (show_c[i]) begin
                hex_c[SEG_W*i +: SEG_W] = seg_c[i];
            end else begin
                hex_c[SEG_W*i +: SEG_W] = SEG_BLANK;
            end
        end
    end

    // Next-state and datapath; a LOAD on the final shift restarts directly.
    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        ovf_acc_d  = ovf_acc_q;
        pend_d     = pend_q;
        pend_val_d = pend_val_q;
        hex_d      = hex_q;
        ovf_d      = ovf_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (LOAD) begin
                    bin_d     = SCORE;
                    bcd_d     = '0;
                    cnt_d     = '0;
                    ovf_acc_d = 1'b0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                bin_d     = bin_q << 1;
                bcd_d     = bcd_shift_c;
                cnt_d     = cnt_q + CNT_W'(1);
                ovf_acc_d = commit_ovf_c;
                if (LOAD) begin
                    pend_d     = 1'b1;
                    pend_val_d = SCORE;
                end
                if (last_c) begin
                    hex_d  = hex_c;
                    ovf_d  = commit_ovf_c;
                    done_d = 1'b1;
                    if (LOAD || pend_q) begin
                        bin_d     = LOAD ? SCORE : pend_val_q;
                        bcd_d     = '0;
                        cnt_d     = '0;
                        ovf_acc_d = 1'b0;
                        pend_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            bin_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            ovf_acc_q  <= 1'b0;
            pend_q     <= 1'b0;
            pend_val_q <= '0;
            hex_q      <= HEX_RST;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            ovf_acc_q  <= ovf_acc_d;
            pend_q     <= pend_d;
            pend_val_q <= pend_val_d;
            hex_q      <= hex_d;
            ovf_q      <= ovf_d;
            done_q     <= done_d;
        end
    end

    assign BUSY       = (state_q == SHIFT);
    assign DONE       = done_q;
    assign OVF        = ovf_q;
    assign HEX_DIGITS = hex_q;
    assign HEX_LABEL  = {SEG_S, SEG_C, SEG_O, SEG_R, SEG_E};

endmodule

// File: tb/tb_score_bcd_display.sv
// Scoreboard bench for score_bcd_display: a 3-digit and a 2-digit instance share stimulus.
module tb_score_bcd_display;

    localparam int W = 8;

    localparam logic [6:0] T_SEG [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                          7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    localparam logic [6:0] T_DASH  = 7'h3F;
    localparam logic [6:0] T_BLANK = 7'h7F;

    typedef struct {
        int val;
        int cyc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [7:0]  score;
    logic        load;
    logic        busy3, done3, ovf3;
    logic        busy2, done2, ovf2;
    logic [20:0] hex3;
    logic [13:0] hex2;
    logic [34:0] label3, label2;

    exp_t sb[$];
    int   cyc;
    int   n_checks;
    int   n_pass;
    int   n_done;

    score_bcd_display #(.WIDTH(W), .DIGITS(3)) u_dut3 (
        .CLOCK_50(clk), .RESET_N(rst_n), .SCORE(score), .LOAD(load),
        .BUSY(busy3), .DONE(done3), .OVF(ovf3), .HEX_DIGITS(hex3), .HEX_LABEL(label3)
    );

    score_bcd_display #(.WIDTH(W), .DIGITS(2)) u_dut2 (
        .CLOCK_50(clk), .RESET_N(rst_n), .SCORE(score), .LOAD(load),
        .BUSY(busy2), .DONE(done2), .OVF(ovf2), .HEX_DIGITS(hex2), .HEX_LABEL(label2)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [34:0] got, input logic [34:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic ref_ovf(int v, int nd);
        int lim = 1;
        for (int i = 0; i < nd; i++) lim *= 10;
        return v >= lim;
    endfunction

    function automatic logic [20:0] ref_hex(int v, int nd);
        logic [20:0] h = '0;
        int d[7];
        int p = 1;
        int top = 0;
        for (int i = 0; i < nd; i++) begin
            d[i] = (v / p) % 10;
            if (d[i] != 0) top = i;
            p *= 10;
        end
        for (int i = 0; i < nd; i++) begin
            if (ref_ovf(v, nd)) begin
                h[7*i +: 7] = T_DASH;
            end else begin
`ifdef SCORE_ZERO_BLANK_EN
                h[7*i +: 7] = (i <= top) ? T_SEG[d[i]] : T_BLANK;
`else
                h[7*i +: 7] = T_SEG[d[i]];
`endif
            end
        end
        return h;
    endfunction

    task automatic push(input int v, input int c);
        exp_t e;
        e.val = v;
        e.cyc = c;
        sb.push_back(e);
    endtask

    // Compare committed results against the scoreboard on every DONE.
    always @(negedge clk) begin
        if (done3 || done2) begin
            exp_t e;
            n_done++;
            chk("done3", 35'(done3), 35'(1));
            chk("done2", 35'(done2), 35'(1));
            if (sb.size() == 0) begin
                chk("done_unexpected", 35'(done3 | done2), 35'(0));
            end else begin
                e = sb.pop_front();
                chk("done_cycle", 35'(cyc), 35'(e.cyc));
                chk("hex3", 35'(hex3), 35'(ref_hex(e.val, 3)));
                chk("ovf3", 35'(ovf3), 35'(ref_ovf(e.val, 3)));
                chk("hex2", 35'(hex2), 35'(ref_hex(e.val, 2)));
                chk("ovf2", 35'(ovf2), 35'(ref_ovf(e.val, 2)));
            end
        end
    end

    task automatic single(input int v);
        @(negedge clk);
        score = 8'(v);
        load  = 1'b1;
        push(v, cyc + 1 + W);
        @(negedge clk);
        load = 1'b0;
        for (int k = 0; k < W; k++) begin
            chk("busy_high", 35'(busy3 & busy2), 35'(1));
            @(negedge clk);
        end
        chk("busy_low", 35'(busy3 | busy2), 35'(0));
        @(negedge clk);
        chk("done_pulse_end", 35'(done3 | done2), 35'(0));
    endtask

    initial begin
        int base;
        int d0;
        cyc      = 0;
        n_checks = 0;
        n_pass   = 0;
        n_done   = 0;
        rst_n    = 1'b0;
        load     = 1'b0;
        score    = '0;
        repeat (2) @(negedge clk);

        chk("rst_busy", 35'({busy3, busy2}), 35'(0));
        chk("rst_done", 35'({done3, done2}), 35'(0));
        chk("rst_ovf",  35'({ovf3, ovf2}), 35'(0));
        chk("rst_hex3", 35'(hex3), 35'(ref_hex(0, 3)));
        chk("rst_hex2", 35'(hex2), 35'(ref_hex(0, 2)));
        chk("label3", label3, {7'h12, 7'h46, 7'h40, 7'h2F, 7'h06});
        chk("label2", label2, {7'h12, 7'h46, 7'h40, 7'h2F, 7'h06});
        rst_n = 1'b1;

        single(0);
        single(255);
        single(42);
        single(100);
        single(99);
        single(7);
        single(10);
        single(int'($urandom_range(0, 255)));
        single(int'($urandom_range(0, 255)));

        // Two loads while busy: only the latest is converted, with no idle gap.
        @(negedge clk);
        base  = cyc;
        score = 8'd17;
        load  = 1'b1;
        push(17, base + 1 + W);
        push(201, base + 1 + 2 * W);
        @(negedge clk); load = 1'b0;
        @(negedge clk); score = 8'd200; load = 1'b1;
        @(negedge clk); score = 8'd201;
        @(negedge clk); load = 1'b0;
        while (cyc < base + 2 * W) begin
            @(negedge clk);
            chk("pend_busy", 35'(busy3 & busy2), 35'(1));
        end
        @(negedge clk);
        chk("pend_busy_low", 35'(busy3 | busy2), 35'(0));

        // LOAD on the final shift restarts immediately.
        @(negedge clk);
        base  = cyc;
        score = 8'd33;
        load  = 1'b1;
        push(33, base + 1 + W);
        push(250, base + 1 + 2 * W);
        @(negedge clk); load = 1'b0;
        while (cyc < base + W) @(negedge clk);
        score = 8'd250;
        load  = 1'b1;
        @(negedge clk);
        load = 1'b0;
        chk("final_load_busy", 35'(busy3 & busy2), 35'(1));
        while (cyc < base + 2 * W + 1) @(negedge clk);
        @(negedge clk);
        chk("final_load_idle", 35'(busy3 | busy2), 35'(0));

        single(100);

        // Reset during shift 4 of 123 with a pending value queued.
        @(negedge clk);
        score = 8'd123;
        load  = 1'b1;
        @(negedge clk); load = 1'b0;
        @(negedge clk); score = 8'd50; load = 1'b1;
        @(negedge clk); load = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 35'({busy3, busy2}), 35'(0));
        chk("mid_rst_done", 35'({done3, done2}), 35'(0));
        chk("mid_rst_ovf",  35'({ovf3, ovf2}), 35'(0));
        chk("mid_rst_hex3", 35'(hex3), 35'(ref_hex(0, 3)));
        chk("mid_rst_hex2", 35'(hex2), 35'(ref_hex(0, 2)));
        @(negedge clk);
        rst_n = 1'b1;
        d0 = n_done;
        repeat (20) @(negedge clk);
        chk("no_done_after_rst", 35'(n_done), 35'(d0));
        chk("idle_after_rst", 35'({busy3, busy2}), 35'(0));

        single(98);

        for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clk);
        chk("sb_drain", 35'(sb.size()), 35'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/score_bcd_display.md
# score_bcd_display

Parametrised, sequential score-to-seven-segment driver for the DE2-115 HEX bank. It converts a WIDTH-bit binary score into DIGITS decimal digits using an iterative shift-and-add-3 (double-dabble) engine, one bit per clock. It registers active-low segment patterns with a LOAD/BUSY/DONE handshake, overflow indication and a static "SCORE" label. It sits between the game/score logic and the board HEX pins, and is the clocked, width-generic successor to the combinational score display.

## Interface
- WIDTH, 8: score input width in bits, 1..20.
- DIGITS, 3: number of decimal digits driven, 1..7.
- CLOCK_50 input 1: system clock; all state updates on the rising edge.
- RESET_N input 1: asynchronous, active-low reset.
- SCORE input WIDTH: unsigned binary score, sampled only when LOAD is accepted.
- LOAD input 1: convert-request strobe, level-sampled each cycle.
- BUSY output 1: high while a conversion is in progress.
- DONE output 1: one-cycle pulse, coincident with new HEX_DIGITS.
- OVF output 1: last committed value exceeded 10^DIGITS−1.
- HEX_DIGITS output 7*DIGITS: digit i occupies [7i+6:7i]; i=0 is the ones digit; active-low, bit 6 = g … bit 0 = a.
- HEX_LABEL output 35: constant S,C,O,R,E; S in [34:28], E in [6:0].

## Operation
- States: IDLE, SHIFT. A shift register holds the binary value, a BCD register holds 4*DIGITS bits, and a bit counter is sized $clog2(WIDTH+1).
- IDLE + LOAD=1:
  - load SCORE into the binary register;
  - clear the BCD register, counter and overflow flag;
  - go to SHIFT.
- SHIFT, each cycle:
  - add 3 to every BCD nibble ≥5;
  - shift {bcd, bin} left by 1;
  - increment the counter.
  - If the bit shifted out of the top nibble is 1, set the sticky overflow flag.
- SHIFT, after the WIDTH-th shift:
  - encode the post-shift BCD into HEX_DIGITS;
  - OVF <= overflow flag;
  - DONE <= 1 for one cycle;
  - go to IDLE, or restart from the pending value (see below).
- On overflow, every digit shows dash (7'b0111111) instead of the digit pattern.
- BUSY = (state == SHIFT).
- LOAD while BUSY:
  - SCORE is captured into a pending register and a pending flag is set; the latest value wins.
  - The conversion in progress is not disturbed.
- Commit with pending set:
  - the pending value is loaded;
  - the pending flag is cleared;
  - the block stays in SHIFT with no IDLE cycle.
- LOAD in the same cycle as the final shift counts as pending, so the next conversion starts immediately.
- HEX_LABEL is constant and independent of reset and state.
- Nibble values >9 cannot occur. The encoder default is blank (7'b1111111).

## Timing
- LOAD accepted at rising edge E0. BUSY is high from E0. HEX_DIGITS, OVF and DONE update at E0+WIDTH.
- BUSY falls at E0+WIDTH unless a value is pending.
- Back-to-back throughput: one result per WIDTH cycles.
- Reset values:
  - state IDLE; BUSY=0, DONE=0, OVF=0;
  - pending flag cleared;
  - HEX_DIGITS displays value 0 per the configuration rule.
- Reset asserted mid-conversion aborts it. Outputs return to reset values asynchronously, and the pending value is discarded.
- WIDTH=1: a single SHIFT cycle, with DONE one cycle after LOAD.

## Configuration
- SCORE_ZERO_BLANK_EN defined:
  - digits above the most significant non-zero digit output blank (7'b1111111);
  - the ones digit is always shown;
  - overflow dashes override blanking.
- Undefined: all DIGITS digits are shown, including leading zeros.
- Affects reset display: with the macro, only digit 0 shows "0"; without it, all digits show "0".

## Structure
- Package score_display_pkg:
  - segment constants SEG_DIGIT[0:9], SEG_BLANK, SEG_DASH;
  - letter constants SEG_S, SEG_C, SEG_O, SEG_R, SEG_E;
  - state enum type.
- Sub-module seg7_encode: combinational 4-bit BCD to 7-bit active-low pattern, instantiated DIGITS times via generate.
- The top level holds the FSM, datapath, pending logic, blanking mask and registered outputs.

## Test plan
- WIDTH=8, DIGITS=3, SCORE=0, LOAD pulse -> DONE at +8 cycles. HEX_DIGITS = SEG0,SEG0,SEG0 without the macro; blank,blank,SEG0 with it. OVF=0.
- SCORE=255 -> digits 2,5,5 after exactly 8 cycles; BUSY high for 8 cycles.
- SCORE=42 with SCORE_ZERO_BLANK_EN -> digit2 blank, digit1 SEG4, digit0 SEG2.
- DIGITS=2, SCORE=100 -> all digits SEG_DASH and OVF=1. A following SCORE=99 -> 9,9 and OVF=0.
- LOAD 17, then LOAD 200 and LOAD 201 while BUSY -> DONE shows 17; the second conversion starts with no IDLE gap; the next DONE shows 201; 200 is never shown.
- RESET_N low at shift 4 of SCORE=123 -> BUSY=0 and reset display at once; after release, no DONE without a new LOAD.
